// File: rtl/adc_trigger_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// adc_trigger_sequencer_pkg : state encodings and defaults shared with CSR readback
// Revision: 1.0
// ============================================================================
package adc_trigger_sequencer_pkg;

  localparam int CNT_WIDTH_DEFAULT = 16;
  localparam int STATE_WIDTH       = 3;

  typedef logic [STATE_WIDTH-1:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_PRE  = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_POST = 3'd3;
  localparam state_t ST_DONE = 3'd4;
  localparam state_t ST_HOLD = 3'd5;

endpackage
`default_nettype wire

// File: rtl/adc_trigger_sequencer_sample_window_counter.sv
`default_nettype none
// ============================================================================
// sample_window_counter : loadable sample counter with full / last-sample flags
// Revision: 1.0
// ============================================================================
module sample_window_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_load_val,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_target,
  output logic                 o_full,
  output logic                 o_last
);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [CNT_WIDTH:0]   w_count_inc;

  // One extra bit so a target of all-ones still compares without wrapping.
  assign w_count_inc = {1'b0, count_q} + {{CNT_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (i_en) begin
      count_d = w_count_inc[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_full = (count_q == i_target);
  assign o_last = i_en & (w_count_inc == {1'b0, i_target});

endmodule
`default_nettype wire

// File: rtl/adc_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// adc_trigger_sequencer : pretrigger / trigger / posttrigger / holdoff sequencer
// Revision: 1.0
// ============================================================================
module adc_trigger_sequencer
  import adc_trigger_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH  = CNT_WIDTH_DEFAULT,
  parameter int TCNT_WIDTH = 16
) (
  input  logic                  adcClk,
  input  logic                  adcReset_n,
  input  logic                  armStrobe,
  input  logic                  abortStrobe,
  input  logic                  autoRearm,
  input  logic [CNT_WIDTH-1:0]  pretrigCount,
  input  logic [CNT_WIDTH-1:0]  posttrigCount,
  input  logic [CNT_WIDTH-1:0]  holdoffCount,
  input  logic                  adcValidOut,
  input  logic                  adcUseThisSample,
  input  logic                  adcExceedsThreshold,
  output logic                  captureEnable,
  output logic                  triggerMarker,
  output logic                  acqDone,
  output logic                  busy,
  output logic [2:0]            state,
  output logic [TCNT_WIDTH-1:0] triggerCount
);

  localparam logic [CNT_WIDTH-1:0] C_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic                   prev_exc_q, prev_exc_d;
  logic [CNT_WIDTH-1:0]   pre_q, pre_d;
  logic [CNT_WIDTH-1:0]   post_q, post_d;
  logic [CNT_WIDTH-1:0]   hold_q, hold_d;
  logic                   auto_q, auto_d;
  logic                   capture_q, capture_d;
  logic                   marker_q, marker_d;
  logic                   done_q, done_d;
  logic [TCNT_WIDTH-1:0]  tcount_q, tcount_d;

  logic                   w_sample;
  logic                   w_trig_edge;
  logic                   w_arm_ok;
  logic [CNT_WIDTH-1:0]   w_post_eff;
  logic                   w_cnt_load;
  logic [CNT_WIDTH-1:0]   w_cnt_load_val;
  logic                   w_cnt_en;
  logic [CNT_WIDTH-1:0]   w_cnt_target;
  logic                   w_cnt_full;
  logic                   w_cnt_last;

  assign w_sample    = adcValidOut & adcUseThisSample;
  assign w_trig_edge = w_sample & adcExceedsThreshold & ~prev_exc_q;
  assign w_arm_ok    = armStrobe & ~abortStrobe & (state_q == ST_IDLE);
  assign w_post_eff  = (post_q == '0) ? C_ONE : post_q;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge adcClk or negedge adcReset_n) begin
    if (!adcReset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (abortStrobe) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (armStrobe)   state_d = (pretrigCount == '0) ? ST_WAIT : ST_PRE;
        ST_PRE:  if (w_cnt_last)  state_d = ST_WAIT;
        ST_WAIT: if (w_trig_edge) state_d = ST_POST;
        ST_POST: if (w_cnt_full || w_cnt_last) state_d = ST_DONE;
        ST_DONE: state_d = auto_q ? ST_HOLD : ST_IDLE;
        ST_HOLD: if (w_cnt_full || w_cnt_last) state_d = (pre_q == '0) ? ST_WAIT : ST_PRE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    capture_d = 1'b0;
    marker_d  = 1'b0;
    tcount_d  = tcount_q;
    if (!abortStrobe) begin
      case (state_q)
        ST_PRE, ST_WAIT: capture_d = w_sample;
        // A full counter here means the trigger sample already closed the window.
        ST_POST:         capture_d = w_sample & ~w_cnt_full;
        default:         capture_d = 1'b0;
      endcase
      if ((state_q == ST_WAIT) && w_trig_edge) begin
        marker_d = 1'b1;
        if (tcount_q != '1) begin
          tcount_d = tcount_q + 1'b1;
        end
      end
    end
    done_d = (state_d == ST_DONE);
  end

  // ------------------------------------------------------ config and history
  always_comb begin
    pre_d      = pre_q;
    post_d     = post_q;
    hold_d     = hold_q;
    auto_d     = auto_q;
    prev_exc_d = w_sample ? adcExceedsThreshold : prev_exc_q;
    if (w_arm_ok) begin
      pre_d  = pretrigCount;
      post_d = posttrigCount;
      hold_d = holdoffCount;
      auto_d = autoRearm;
    end
  end

  always_ff @(posedge adcClk or negedge adcReset_n) begin
    if (!adcReset_n) begin
      prev_exc_q <= 1'b0;
      pre_q      <= '0;
      post_q     <= '0;
      hold_q     <= '0;
      auto_q     <= 1'b0;
      capture_q  <= 1'b0;
      marker_q   <= 1'b0;
      done_q     <= 1'b0;
      tcount_q   <= '0;
    end else begin
      prev_exc_q <= prev_exc_d;
      pre_q      <= pre_d;
      post_q     <= post_d;
      hold_q     <= hold_d;
      auto_q     <= auto_d;
      capture_q  <= capture_d;
      marker_q   <= marker_d;
      done_q     <= done_d;
      tcount_q   <= tcount_d;
    end
  end

  // ------------------------------------------------------------ window counter
  // Reloaded on every state change; the trigger sample counts as post sample 1.
  assign w_cnt_load     = (state_d != state_q);
  assign w_cnt_load_val = (state_d == ST_POST) ? C_ONE : '0;
  assign w_cnt_en       = w_sample & ~w_cnt_full &
                          ((state_q == ST_PRE) || (state_q == ST_POST) || (state_q == ST_HOLD));

  always_comb begin
    case (state_q)
      ST_PRE:  w_cnt_target = pre_q;
      ST_POST: w_cnt_target = w_post_eff;
      ST_HOLD: w_cnt_target = hold_q;
      default: w_cnt_target = '0;
    endcase
  end

  sample_window_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_window_counter (
    .clk        (adcClk),
    .rst_n      (adcReset_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_en       (w_cnt_en),
    .i_target   (w_cnt_target),
    .o_full     (w_cnt_full),
    .o_last     (w_cnt_last)
  );

  assign captureEnable = capture_q;
  assign triggerMarker = marker_q;
  assign acqDone       = done_q;
  assign busy          = (state_q != ST_IDLE);
  assign state         = state_q;
  assign triggerCount  = tcount_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// tb_adc_trigger_sequencer : directed stimulus with a cycle-level scoreboard
// Revision: 1.0
// ============================================================================
module tb_adc_trigger_sequencer;

  localparam int CW = 16;
  localparam int TW = 2;

  logic          adcClk = 1'b0;
  logic          adcReset_n = 1'b0;
  logic          armStrobe = 1'b0;
  logic          abortStrobe = 1'b0;
  logic          autoRearm = 1'b0;
  logic [CW-1:0] pretrigCount = '0;
  logic [CW-1:0] posttrigCount = '0;
  logic [CW-1:0] holdoffCount = '0;
  logic          adcValidOut = 1'b0;
  logic          adcUseThisSample = 1'b0;
  logic          adcExceedsThreshold = 1'b0;
  logic          captureEnable;
  logic          triggerMarker;
  logic          acqDone;
  logic          busy;
  logic [2:0]    state;
  logic [TW-1:0] triggerCount;

  adc_trigger_sequencer #(
    .CNT_WIDTH  (CW),
    .TCNT_WIDTH (TW)
  ) dut (
    .adcClk              (adcClk),
    .adcReset_n          (adcReset_n),
    .armStrobe           (armStrobe),
    .abortStrobe         (abortStrobe),
    .autoRearm           (autoRearm),
    .pretrigCount        (pretrigCount),
    .posttrigCount       (posttrigCount),
    .holdoffCount        (holdoffCount),
    .adcValidOut         (adcValidOut),
    .adcUseThisSample    (adcUseThisSample),
    .adcExceedsThreshold (adcExceedsThreshold),
    .captureEnable       (captureEnable),
    .triggerMarker       (triggerMarker),
    .acqDone             (acqDone),
    .busy                (busy),
    .state               (state),
    .triggerCount        (triggerCount)
  );

  always #5 adcClk = ~adcClk;

  typedef struct packed {
    logic          cap;
    logic          mark;
    logic          done;
    logic          busy;
    logic [2:0]    st;
    logic [TW-1:0] tc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;
  int   n_cap = 0;
  int   n_mark = 0;
  int   n_done = 0;

  // Reference model: counts remaining samples downward.
  logic [2:0]    m_state;
  int            m_rem;
  logic          m_prev;
  int            m_pre, m_post, m_hold;
  logic          m_auto;
  logic [TW-1:0] m_trig;

  task automatic model_reset();
    m_state = 3'd0; m_rem = 0; m_prev = 1'b0;
    m_pre = 0; m_post = 0; m_hold = 0; m_auto = 1'b0; m_trig = '0;
  endtask

  task automatic model_step(input logic v, input logic u, input logic e,
                            input logic arm, input logic abt, output exp_t x);
    logic s, t, cap, mark, go;
    logic [2:0] nxt;
    s = v & u;
    t = s & e & ~m_prev;
    cap = 1'b0; mark = 1'b0; go = 1'b0;
    nxt = m_state;
    if (abt) begin
      nxt = 3'd0;
    end else begin
      case (m_state)
        3'd0: if (arm) begin
          m_pre = int'(pretrigCount); m_post = int'(posttrigCount);
          m_hold = int'(holdoffCount); m_auto = autoRearm;
          if (m_pre == 0) nxt = 3'd2;
          else begin nxt = 3'd1; m_rem = m_pre; end
        end
        3'd1: begin
          cap = s;
          if (s) begin m_rem--; if (m_rem == 0) nxt = 3'd2; end
        end
        3'd2: begin
          cap = s;
          if (t) begin
            mark = 1'b1;
            if (m_trig != '1) m_trig = m_trig + 1'b1;
            nxt = 3'd3;
            m_rem = ((m_post == 0) ? 1 : m_post) - 1;
          end
        end
        3'd3: begin
          if (m_rem == 0) nxt = 3'd4;
          else begin
            cap = s;
            if (s) begin m_rem--; if (m_rem == 0) nxt = 3'd4; end
          end
        end
        3'd4: begin
          if (m_auto) begin nxt = 3'd5; m_rem = m_hold; end
          else nxt = 3'd0;
        end
        3'd5: begin
          if (m_rem == 0) go = 1'b1;
          else if (s) begin m_rem--; if (m_rem == 0) go = 1'b1; end
          if (go) begin
            if (m_pre == 0) nxt = 3'd2;
            else begin nxt = 3'd1; m_rem = m_pre; end
          end
        end
        default: nxt = 3'd0;
      endcase
    end
    if (s) m_prev = e;
    m_state = nxt;
    x = '{cap: cap, mark: mark, done: (nxt == 3'd4), busy: (nxt != 3'd0), st: nxt, tc: m_trig};
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic u, input logic e, input logic arm, input logic abt);
    exp_t x, got;
    adcValidOut = v; adcUseThisSample = u; adcExceedsThreshold = e;
    armStrobe = arm; abortStrobe = abt;
    model_step(v, u, e, arm, abt, x);
    q.push_back(x);
    @(posedge adcClk);
    #1;
    cyc_no++;
    got = '{cap: captureEnable, mark: triggerMarker, done: acqDone, busy: busy, st: state, tc: triggerCount};
    x = q.pop_front();
    checks++;
    assert (got === x) else begin
      errors++;
      $error("FAIL cycle%0d observed=%b expected=%b (cap,mark,done,busy,state,tcount)", cyc_no, got, x);
    end
    n_cap  += int'(captureEnable);
    n_mark += int'(triggerMarker);
    n_done += int'(acqDone);
    armStrobe = 1'b0; abortStrobe = 1'b0;
  endtask

  task automatic samp(input logic e);
    cyc(1'b1, 1'b1, e, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Config inputs are scrambled right after the arm; only the latched copy may matter.
  task automatic arm(input int pre, input int post, input int hold, input logic au);
    pretrigCount = CW'(pre); posttrigCount = CW'(post); holdoffCount = CW'(hold); autoRearm = au;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pretrigCount = CW'(7); posttrigCount = CW'(6); holdoffCount = CW'(9); autoRearm = ~au;
  endtask

  task automatic do_reset(input string tag);
    adcReset_n = 1'b0;
    #2;
    check({tag, "_async"}, {23'd0, captureEnable, triggerMarker, acqDone, busy, state, triggerCount}, 32'd0);
    @(posedge adcClk);
    #1;
    check({tag, "_held"}, {23'd0, captureEnable, triggerMarker, acqDone, busy, state, triggerCount}, 32'd0);
    adcReset_n = 1'b1;
    model_reset();
    q.delete();
    n_cap = 0; n_mark = 0; n_done = 0;
  endtask

  initial begin
    model_reset();
    @(posedge adcClk);
    #1;
    do_reset("rst0");

    // Basic acquisition, no rearm.
    arm(4, 3, 0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      samp(i == 7);
      if (i % 3 == 0) idle(1);
    end
    idle(3);
    check("t1_cap", n_cap, 9);
    check("t1_mark", n_mark, 1);
    check("t1_tcount", triggerCount, 1);
    check("t1_done", n_done, 1);
    check("t1_idle", state, 0);

    // Level held across PRE->WAIT must not trigger; fall then rise does.
    do_reset("rst2");
    arm(3, 2, 0, 1'b0);
    for (int i = 0; i < 6; i++) samp(1'b1);
    check("t2_no_trig", triggerCount, 0);
    check("t2_waiting", state, 2);
    samp(1'b0);
    samp(1'b1);
    samp(1'b0);
    idle(3);
    check("t2_tcount", triggerCount, 1);
    check("t2_cap", n_cap, 9);
    check("t2_done", n_done, 1);

    // Alternate qualified / unqualified cycles, with a flag seen only unqualified.
    do_reset("rst3");
    arm(2, 2, 0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b1, (i % 2 == 0), (i == 5) || (i == 6), 1'b0, 1'b0);
    idle(2);
    check("t3_cap", n_cap, 5);
    check("t3_tcount", triggerCount, 1);
    check("t3_done", n_done, 1);

    // Auto-rearm with holdoff; pulses inside holdoff are ignored.
    do_reset("rst4");
    arm(1, 2, 5, 1'b1);
    samp(1'b0);
    samp(1'b1);
    samp(1'b0);
    idle(1);
    check("t4_hold", state, 5);
    samp(1'b0); samp(1'b0); samp(1'b1); samp(1'b0); samp(1'b1);
    check("t4_holdoff_ignored", triggerCount, 1);
    check("t4_rearmed", state, 1);
    samp(1'b0);
    samp(1'b1);
    samp(1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    check("t4_tcount", triggerCount, 2);
    check("t4_done", n_done, 2);

    // Abort during POST, arm ignored while busy, arm+abort together.
    do_reset("rst5");
    arm(2, 4, 0, 1'b0);
    samp(1'b0); samp(1'b0); samp(1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    samp(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_abort_idle", state, 0);
    idle(2);
    check("t5_no_done", n_done, 0);
    check("t5_tcount_kept", triggerCount, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("t5_arm_abort_busy", busy, 0);
    samp(1'b0); samp(1'b1);
    idle(2);
    check("t5_still_idle", busy, 0);

    // Zero-length windows with rearm; trigger counter saturation.
    do_reset("rst6");
    arm(0, 0, 0, 1'b1);
    check("t6_direct_wait", state, 2);
    for (int k = 0; k < 5; k++) begin
      samp(1'b1);
      samp(1'b0);
      idle(2);
    end
    check("t6_saturate", triggerCount, 3);
    check("t6_marks", n_mark, 5);
    check("t6_done", n_done, 5);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    arm(3, 1, 0, 1'b0);
    samp(1'b0); samp(1'b0); samp(1'b0); samp(1'b0);
    check("t6_mid_wait", state, 2);
    do_reset("rst6_mid");
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
